arm_shift_unit: RTL and testbench
=================================

Name: arm_shift_unit

Overview:
- Parametrised, handshaked operand-2 shifter for the ARM7 datapath.
- Replaces the combinational shifter with a registered unit.
- Accepts immediate-amount and register-amount shift requests. Register-amount requests take one extra internal cycle to latch the Rs value, mirroring ARM7 I-cycle timing.
- Implements full ARM semantics: RRX, LSR/ASR #0 encodings meaning shift-by-DATA_W, and register amounts 0..255. Result goes to the ALU operand-B path.

Parameters:
- DATA_W, 32: operand width; power of two, >= 8. SH_W = log2(DATA_W).
- AMT_W, 8: register shift-amount width taken from rs_data[AMT_W-1:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_shift_type  in  2  0=LSL 1=LSR 2=ASR 3=ROR
- in_use_reg  in  1  1 = amount from rs_data; 0 = immediate
- in_shift_imm  in  SH_W  immediate amount
- in_data  in  DATA_W  value to shift (Rm)
- in_carry  in  1  current C flag
- rs_data  in  DATA_W  Rs value; valid in the cycle after a register-mode accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  shifted operand
- out_carry  out  1  shifter carry-out
- out_zero  out  1  out_data == 0 (optional feature)
- out_neg  out  1  out_data[DATA_W-1] (optional feature)

Behaviour:
- Reset (synchronous, active-high): state IDLE; out_valid=0, out_data=0, out_carry=0, out_zero=0, out_neg=0; latched amount=0. Reset mid-operation abandons the request without emitting it.
- States:
  - IDLE: in_ready=1.
  - AMT: in_ready=0.
  - OUT: out_valid=1; in_ready=out_ready.
- Accept occurs when in_valid && in_ready. The unit captures type, data, carry and use_reg.
  - Immediate request: result is computed and registered at the accept edge; next state OUT (latency 1).
  - Register request: next state AMT. In AMT the unit samples rs_data[AMT_W-1:0] into the amount register, computes and registers the result at the end of AMT, then goes to OUT (latency 2).
- OUT with out_ready=1 and a new accept: back-to-back issue. Immediate goes to OUT with the new result; register goes to AMT with out_valid=0 next cycle. OUT with out_ready=1 and no accept goes to IDLE.
- OUT with out_ready=0: hold out_data, out_carry and flags stable; no accept.
- Immediate semantics (n = in_shift_imm):
  - LSL #0: data unchanged, C=in_carry.
  - LSR #0 / ASR #0: treated as shift by DATA_W.
  - ROR #0: RRX, giving {in_carry, data[W-1:1]} with C=data[0].
  - Otherwise: as register semantics below.
- Register semantics (n = latched amount, 0..2^AMT_W-1):
  - n=0, any type: data unchanged, C=in_carry.
  - LSL: n<W gives data<<n with C=data[W-n]; n==W gives 0 with C=data[0]; n>W gives 0 with C=0.
  - LSR: n<W gives data>>n with C=data[n-1]; n==W gives 0 with C=data[W-1]; n>W gives 0 with C=0.
  - ASR: n<W gives arithmetic shift with C=data[n-1]; n>=W gives all sign bits with C=data[W-1].
  - ROR: m=n[SH_W-1:0]. If m==0 and n!=0: data unchanged, C=data[W-1]. Else rotate right by m, C=data[m-1].
- All index arithmetic is done at SH_W+1 or AMT_W bits; no truncation aliasing (e.g. LSL 32 must not alias LSL 0).
- No simulation display output in RTL.

Optional Feature:
- ARM_SHIFT_UNIT_FLAGS_EN defined: out_zero and out_neg are registered alongside out_data, from the same result.
- Undefined: out_zero and out_neg tied 0. Ports remain present so the bench is unchanged.

Test Plan:
- Reset, then immediate LSL #4, data=0x0000_00F1, C=0 -> 1 cycle later out_data=0x0000_0F10, out_carry=0, out_valid=1.
- Immediate ROR #0 (RRX), data=0x0000_0003, in_carry=1 -> out_data=0x8000_0001, out_carry=1. Immediate LSR #0, data=0x8000_0000 -> out_data=0, out_carry=1.
- Register LSR, rs_data=32 in AMT cycle, data=0x8000_0001 -> 2-cycle latency, out_data=0, out_carry=1. Repeat with rs_data=33 -> out_data=0, out_carry=0. Repeat with rs_data=0x120 (amount 0x20) -> out_data=0, out_carry=1.
- Register ROR, rs_data=64, data=0x8000_0000 -> out_data unchanged, out_carry=1. Register ASR rs_data=200, data=0x8000_0000 -> out_data=0xFFFF_FFFF, out_carry=1.
- Backpressure: out_ready=0 for 3 cycles -> out_data stable, in_ready=0. Then raise out_ready with a new immediate request -> accepted the same cycle, next result 1 cycle later.
- Reset asserted in AMT -> next cycle IDLE, out_valid=0, no stale result. With ARM_SHIFT_UNIT_FLAGS_EN defined, LSL #1 of 0x8000_0000 -> out_zero=1, out_neg=0.

Source files
------------

// File: rtl/arm_shift_unit.sv
// Registered, handshaked ARM7 operand-2 shifter (LSL/LSR/ASR/ROR/RRX with full ARM amount rules).
// Define ARM_SHIFT_UNIT_FLAGS_EN to register out_zero/out_neg; otherwise both are tied low.
module arm_shift_unit #(
    parameter  int DATA_W = 32,
    parameter  int AMT_W  = 8,
    localparam int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_shift_type,
    input  logic              in_use_reg,
    input  logic [SH_W-1:0]   in_shift_imm,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_carry,
    input  logic [DATA_W-1:0] rs_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic              out_zero,
    output logic              out_neg
);

    localparam int NW = (AMT_W > SH_W + 1) ? AMT_W : SH_W + 1;
    localparam logic [NW-1:0] W_N   = NW'(DATA_W);
    localparam logic [SH_W:0] W_S   = (SH_W + 1)'(DATA_W);

    typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_t;
    typedef enum logic [1:0] {S_IDLE, S_AMT, S_OUT} state_t;

    state_t              state, state_n;
    shift_t              type_q, op_type;
    logic [DATA_W-1:0]   data_q, op_data;
    logic                carry_q, op_carry, op_rrx;
    logic [AMT_W-1:0]    amt_q, amt_cur;
    logic [NW-1:0]       op_amt;
    logic [DATA_W:0]     result;
    logic                accept, load;

    wire unused_rs_hi = ^rs_data[DATA_W-1:AMT_W];

    // Register-amount semantics; returns {carry_out, data_out}. n is wide enough that n==DATA_W never aliases 0.
    function automatic logic [DATA_W:0] shift_fn(shift_t t, logic [DATA_W-1:0] d, logic c,
                                                 logic [NW-1:0] n);
        logic [SH_W-1:0]   m;
        logic [DATA_W:0]   ext;
        logic [DATA_W-1:0] rot;
        logic [DATA_W:0]   r;
        m   = n[SH_W-1:0];
        ext = '0;
        rot = '0;
        r   = {c, d};
        if (n != '0) begin
            case (t)
                SH_LSL: begin
                    ext = {1'b0, d} << m;
                    if (n < W_N)       r = ext;
                    else if (n == W_N) r = {d[0], {DATA_W{1'b0}}};
                    else               r = '0;
                end
                SH_LSR: begin
                    ext = {d, 1'b0} >> m;
                    if (n < W_N)       r = {ext[0], ext[DATA_W:1]};
                    else if (n == W_N) r = {d[DATA_W-1], {DATA_W{1'b0}}};
                    else               r = '0;
                end
                SH_ASR: begin
                    ext = $unsigned($signed({d, 1'b0}) >>> m);
                    if (n < W_N) r = {ext[0], ext[DATA_W:1]};
                    else         r = {d[DATA_W-1], {DATA_W{d[DATA_W-1]}}};
                end
                default: begin
                    // A zero low field (n a multiple of DATA_W) leaves d intact and C = d[MSB] falls out.
                    rot = (d >> m) | (d << (W_S - {1'b0, m}));
                    r   = {rot[DATA_W-1], rot};
                end
            endcase
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = in_use_reg ? S_AMT : S_OUT;
            end
            S_AMT: state_n = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_n = in_valid ? (in_use_reg ? S_AMT : S_OUT) : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign load    = (accept && !in_use_reg) || (state == S_AMT);
    assign amt_cur = (state == S_AMT) ? rs_data[AMT_W-1:0] : amt_q;

    // One shared shifter: live request operands on an accept, captured operands plus Rs while in AMT.
    always_comb begin
        op_type  = shift_t'(in_shift_type);
        op_data  = in_data;
        op_carry = in_carry;
        op_amt   = NW'(in_shift_imm);
        op_rrx   = 1'b0;
        if (state == S_AMT) begin
            op_type  = type_q;
            op_data  = data_q;
            op_carry = carry_q;
            op_amt   = NW'(amt_cur);
        end else if (in_shift_imm == '0) begin
            if (op_type == SH_LSR || op_type == SH_ASR) op_amt = W_N;
            op_rrx = (op_type == SH_ROR);
        end
        if (op_rrx) result = {op_data[0], op_carry, op_data[DATA_W-1:1]};
        else        result = shift_fn(op_type, op_data, op_carry, op_amt);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            type_q    <= SH_LSL;
            data_q    <= '0;
            carry_q   <= 1'b0;
            amt_q     <= '0;
            out_data  <= '0;
            out_carry <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                type_q  <= shift_t'(in_shift_type);
                data_q  <= in_data;
                carry_q <= in_carry;
            end
            if (state == S_AMT) amt_q <= rs_data[AMT_W-1:0];
            if (load) begin
                out_data  <= result[DATA_W-1:0];
                out_carry <= result[DATA_W];
            end
        end
    end

`ifdef ARM_SHIFT_UNIT_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (load) begin
            out_zero <= (result[DATA_W-1:0] == '0);
            out_neg  <= result[DATA_W-1];
        end
    end
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_arm_shift_unit.sv
// Scoreboard bench for arm_shift_unit: a bit-serial reference model predicts each result at accept time.
module tb_arm_shift_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_shift_type = '0;
    logic        in_use_reg = 1'b0;
    logic [4:0]  in_shift_imm = '0;
    logic [31:0] in_data = '0;
    logic        in_carry = 1'b0;
    logic [31:0] rs_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_carry, out_zero, out_neg;

    arm_shift_unit #(.DATA_W(32), .AMT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_shift_type(in_shift_type), .in_use_reg(in_use_reg),
        .in_shift_imm(in_shift_imm), .in_data(in_data), .in_carry(in_carry),
        .rs_data(rs_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry),
        .out_zero(out_zero), .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   bp_random = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Shifts one bit at a time, so amounts past the width fall out naturally from repetition.
    function automatic exp_t model(input logic [1:0] t, input bit use_reg, input logic [4:0] imm,
                                   input logic [31:0] d, input logic c, input logic [31:0] rs);
        exp_t e;
        int   n;
        logic nc;
        if (use_reg)         n = int'(rs[7:0]);
        else if (imm != 0)   n = int'(imm);
        else if (t == 2'd0)  n = 0;
        else if (t == 2'd3) begin
            nc = d[0];
            d  = {c, d[31:1]};
            c  = nc;
            n  = 0;
        end else             n = 32;
        for (int i = 0; i < n; i++) begin
            case (t)
                2'd0: begin c = d[31]; d = d << 1; end
                2'd1: begin c = d[0];  d = d >> 1; end
                2'd2: begin c = d[0];  d = {d[31], d[31:1]}; end
                default: begin c = d[0]; d = {d[0], d[31:1]}; end
            endcase
        end
        e.data  = d;
        e.carry = c;
`ifdef ARM_SHIFT_UNIT_FLAGS_EN
        e.zero  = (d == 32'd0);
        e.neg   = d[31];
`else
        e.zero  = 1'b0;
        e.neg   = 1'b0;
`endif
        return e;
    endfunction

    task automatic issue(input logic [1:0] t, input bit ur, input logic [4:0] imm,
                         input logic [31:0] d, input logic c, input logic [31:0] rs);
        int waited = 0;
        in_valid      = 1'b1;
        in_shift_type = t;
        in_use_reg    = ur;
        in_shift_imm  = imm;
        in_data       = d;
        in_carry      = c;
        #1;
        while (!in_ready) begin
            if (++waited > 100) begin
                n_vec++; n_bad++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        sb.push_back(model(t, ur, imm, d, c, rs));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (ur) begin
            rs_data = rs;
            #1 check("latency_amt_valid", out_valid, 1'b0);
            @(negedge clk);
            rs_data = $urandom;
        end
        #1 check("latency_out_valid", out_valid, 1'b1);
    endtask

    task automatic drain();
        int k = 0;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        while (sb.size() != 0 || out_valid) begin
            if (++k > 100) begin
                n_vec++; n_bad++;
                $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // Monitor: pops the scoreboard on every completed output handshake and polices backpressure holds.
    initial begin : monitor
        exp_t        e;
        logic [31:0] held_d;
        logic        held_c;
        bit          holding;
        holding = 1'b0;
        held_d  = '0;
        held_c  = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (reset || !out_valid) begin
                holding = 1'b0;
            end else begin
                if (holding) begin
                    check("hold_data", out_data, held_d);
                    check("hold_carry", out_carry, held_c);
                end
                if (out_ready) begin
                    holding = 1'b0;
                    if (sb.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_result: got data %0h with nothing pending", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_carry", out_carry, e.carry);
                        check("out_zero", out_zero, e.zero);
                        check("out_neg", out_neg, e.neg);
                    end
                end else begin
                    check("in_ready_backpressure", in_ready, 1'b0);
                    holding = 1'b1;
                    held_d  = out_data;
                    held_c  = out_carry;
                end
            end
        end
    end

    initial begin : backpressure
        forever begin
            @(negedge clk);
            if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [1:0]  t;
        logic [4:0]  imm;
        logic [31:0] d, rs;
        bit          ur;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_carry", out_carry, 1'b0);
        check("reset_out_zero", out_zero, 1'b0);
        check("reset_out_neg", out_neg, 1'b0);

        // Directed corners: immediates, #0 encodings, register amounts at and past the width.
        issue(2'd0, 0, 5'd4, 32'h0000_00F1, 1'b0, 32'd0);
        issue(2'd3, 0, 5'd0, 32'h0000_0003, 1'b1, 32'd0);
        issue(2'd1, 0, 5'd0, 32'h8000_0000, 1'b0, 32'd0);
        issue(2'd2, 0, 5'd0, 32'h7000_0001, 1'b1, 32'd0);
        issue(2'd0, 0, 5'd0, 32'h1234_5678, 1'b1, 32'd0);
        issue(2'd1, 1, 5'd0, 32'h8000_0001, 1'b0, 32'd32);
        issue(2'd1, 1, 5'd0, 32'h8000_0001, 1'b1, 32'd33);
        issue(2'd1, 1, 5'd0, 32'h8000_0001, 1'b0, 32'h120);
        issue(2'd3, 1, 5'd0, 32'h8000_0000, 1'b0, 32'd64);
        issue(2'd2, 1, 5'd0, 32'h8000_0000, 1'b0, 32'd200);
        issue(2'd0, 1, 5'd0, 32'h0000_0001, 1'b0, 32'd32);
        issue(2'd0, 1, 5'd0, 32'h0000_0003, 1'b1, 32'd33);
        issue(2'd2, 1, 5'd0, 32'hC000_0000, 1'b1, 32'd0);
        issue(2'd3, 1, 5'd0, 32'h0000_0081, 1'b0, 32'd8);
        issue(2'd0, 0, 5'd1, 32'h8000_0000, 1'b0, 32'd0);
        drain();

        // Backpressure hold, then same-cycle accept when out_ready rises.
        @(negedge clk);
        out_ready = 1'b0;
        issue(2'd1, 0, 5'd3, 32'hDEAD_BEEF, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        #1 check("accept_on_release", in_ready, 1'b1);
        issue(2'd0, 0, 5'd31, 32'h0000_0003, 1'b0, 32'd0);
        drain();

        // Reset while in AMT abandons the request.
        @(negedge clk);
        in_valid      = 1'b1;
        in_use_reg    = 1'b1;
        in_shift_type = 2'd1;
        in_data       = 32'hFFFF_FFFF;
        #1 check("amt_reset_accept", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rs_data  = 32'd4;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        check("amt_reset_out_valid", out_valid, 1'b0);
        check("amt_reset_in_ready", in_ready, 1'b1);
        check("amt_reset_out_data", out_data, 32'd0);
        check("amt_reset_out_carry", out_carry, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        #1 check("amt_reset_no_stale", out_valid, 1'b0);

        // Randomised traffic with random consumer backpressure.
        bp_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            t   = 2'($urandom_range(0, 3));
            ur  = bit'($urandom_range(0, 1));
            imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       d = 32'h8000_0000 | $urandom;
                1:       d = 32'($urandom_range(0, 3));
                default: d = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rs = 32'($urandom_range(0, 40));
                1:       rs = 32'h100 | 32'($urandom_range(0, 70));
                2:       rs = 32'($urandom_range(60, 255));
                default: rs = $urandom;
            endcase
            issue(t, ur, imm, d, bit'($urandom_range(0, 1)), rs);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        bp_random = 1'b0;
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
